// File: rtl/adc_stream_if.sv
// adc_stream_if: valid/ready sample stream from the FWFT FIFO head.
// The master drives data/valid. The slave drives ready.
interface adc_stream_if #(
    parameter int BITS = 12
);
    logic [BITS-1:0] out_data;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/adc_stream.sv
// adc_stream: ADC capture block.
// - Programmable clock divider generates adc_clk.
// - Samples come from the ADC bus or a test-pattern generator.
// - Samples go into a FWFT FIFO that feeds a valid/ready stream.
// - Dropped samples are counted by a saturating overflow counter.
// Optional build macro ADC_TWOS_COMPLEMENT_EN: inverts the sample MSB
// before storage (offset-binary -> two's complement).
module adc_stream #(
    parameter int BITS  = 12,
    parameter int DIVW  = 8,
    parameter int DEPTH = 4,
    parameter int OVFW  = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             enable,
    input  logic [DIVW-1:0]  div,
    input  logic [1:0]       mode,
    input  logic [BITS-1:0]  adc_data,
    output logic             adc_clk,
    output logic [OVFW-1:0]  overflow_cnt,
    input  logic             clr_overflow,
    adc_stream_if.master     s
);
    localparam int AW = $clog2(DEPTH);

    logic [DIVW-1:0] r_cnt;
    logic [DIVW-1:0] r_d;
    logic            r_en_prev;
    logic [DIVW-1:0] w_div_eff;
    logic [DIVW-1:0] w_d;
    logic [DIVW-1:0] w_d_last;
    logic [DIVW-1:0] w_half;
    logic            w_en_rise;
    logic            w_sample;

    logic [BITS-1:0] r_pcnt;
    logic [BITS-1:0] w_pat_a;
    logic [BITS-1:0] w_pat_5;
    logic [BITS-1:0] w_src;
    logic [BITS-1:0] w_push_data;

    logic [BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [AW:0]     r_count;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    logic [OVFW-1:0] r_ovf;

    // Divider.
    // On the enable-rise cycle the latched divisor is not loaded yet,
    // so the live (clamped) div is used directly. This keeps adc_clk
    // and the wrap point correct from the very first cycle.
    assign w_div_eff = (div < DIVW'(2)) ? DIVW'(2) : div;
    assign w_en_rise = enable && !r_en_prev;
    assign w_d       = w_en_rise ? w_div_eff : r_d;
    assign w_d_last  = w_d - DIVW'(1);
    assign w_half    = w_d >> 1;
    assign w_sample  = enable && (r_cnt == w_d_last);
    assign adc_clk   = nreset && enable && (r_cnt < w_half);

    // Divider counter and divisor latch.
    // The divisor is reloaded only at a period wrap or when enable rises.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cnt     <= '0;
            r_d       <= DIVW'(2);
            r_en_prev <= 1'b0;
        end else begin
            r_en_prev <= enable;
            if (!enable) begin
                r_cnt <= '0;
            end else if (w_sample) begin
                r_cnt <= '0;
                r_d   <= w_div_eff;
            end else begin
                r_cnt <= r_cnt + DIVW'(1);
                if (w_en_rise) begin
                    r_d <= w_div_eff;
                end
            end
        end
    end

    // Alternating test patterns, MSB first: 1010... and 0101...
    always_comb begin
        w_pat_a = '0;
        w_pat_5 = '0;
        for (int unsigned i = 0; i < BITS; i++) begin
            w_pat_a[i] = ((i % 2) == 1);
            w_pat_5[i] = ((i % 2) == 0);
        end
    end

    // Sample source select, with optional MSB inversion before storage.
    always_comb begin
        w_src = '0;
        case (mode)
            2'd0:    w_src = adc_data;
            2'd1:    w_src = {BITS{r_pcnt[0]}};
            2'd2:    w_src = r_pcnt;
            default: w_src = r_pcnt[0] ? w_pat_5 : w_pat_a;
        endcase
`ifdef ADC_TWOS_COMPLEMENT_EN
        w_push_data = {~w_src[BITS-1], w_src[BITS-2:0]};
`else
        w_push_data = w_src;
`endif
    end

    // Pattern counter.
    // Advances on every sample event, including dropped ones.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_pcnt <= '0;
        end else if (w_sample) begin
            r_pcnt <= r_pcnt + BITS'(1);
        end
    end

    // FIFO control.
    // A pop on the same edge frees the slot for a push into a full FIFO.
    assign w_full      = (r_count == (AW+1)'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign s.out_valid = !w_empty;
    assign s.out_data  = w_empty ? '0 : r_mem[r_rd];
    assign w_pop       = !w_empty && s.out_ready;
    assign w_push      = w_sample && (!w_full || w_pop);
    assign w_drop      = w_sample && !w_push;

    // FIFO storage.
    // Contents need no reset: the output is gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= w_push_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    // Saturating drop counter.
    // A clear takes priority over a drop on the same edge.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_ovf <= '0;
        end else if (clr_overflow) begin
            r_ovf <= '0;
        end else if (w_drop && (r_ovf != '1)) begin
            r_ovf <= r_ovf + OVFW'(1);
        end
    end

    assign overflow_cnt = r_ovf;
endmodule

// File: tb/tb_adc_stream.sv
// tb_adc_stream: directed testbench for adc_stream (BITS=12, DIVW=8, DEPTH=4, OVFW=16).
// Inputs are driven on the falling edge. Outputs are checked 1 ns later.
module tb_adc_stream;
    localparam logic [11:0] MSBX =
`ifdef ADC_TWOS_COMPLEMENT_EN
        12'h800;
`else
        12'h000;
`endif

    logic        clk;
    logic        nreset;
    logic        enable;
    logic [7:0]  div;
    logic [1:0]  mode;
    logic [11:0] adc_data;
    logic        adc_clk;
    logic [15:0] overflow_cnt;
    logic        clr_overflow;

    int checks;
    int errors;

    adc_stream_if #(.BITS(12)) u_if ();

    adc_stream #(
        .BITS  (12),
        .DIVW  (8),
        .DEPTH (4),
        .OVFW  (16)
    ) dut (
        .clk          (clk),
        .nreset       (nreset),
        .enable       (enable),
        .div          (div),
        .mode         (mode),
        .adc_data     (adc_data),
        .adc_clk      (adc_clk),
        .overflow_cnt (overflow_cnt),
        .clr_overflow (clr_overflow),
        .s            (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        @(negedge clk);
        nreset          = 1'b0;
        enable          = 1'b0;
        u_if.out_ready  = 1'b0;
        clr_overflow    = 1'b0;
        #2;
        nreset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        enable = 1'b1;
        #12;
        checks++;
        if (u_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", u_if.out_valid);
        end
        checks++;
        if (u_if.out_data !== 12'h000) begin
            errors++;
            $display("FAIL reset_data: got %h expected 000", u_if.out_data);
        end
        checks++;
        if (adc_clk !== 1'b0) begin
            errors++;
            $display("FAIL reset_adc_clk: got %b expected 0", adc_clk);
        end
        checks++;
        if (overflow_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL reset_ovf: got %h expected 0000", overflow_cnt);
        end
        enable = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic test_divider();
        logic [7:0] pat;
        pat = 8'b00110011;
        do_reset();
        div      = 8'd4;
        mode     = 2'd0;
        adc_data = 12'h123;
        enable   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (adc_clk !== pat[i]) begin
                errors++;
                $display("FAIL div4_adc_clk[%0d]: got %b expected %b", i, adc_clk, pat[i]);
            end
            checks++;
            if (u_if.out_valid !== (i >= 4)) begin
                errors++;
                $display("FAIL div4_valid[%0d]: got %b expected %b", i, u_if.out_valid, (i >= 4));
            end
            if (i == 4) begin
                checks++;
                if (u_if.out_data !== (12'h123 ^ MSBX)) begin
                    errors++;
                    $display("FAIL div4_data: got %h expected %h", u_if.out_data, 12'h123 ^ MSBX);
                end
            end
            @(negedge clk);
        end
        enable = 1'b0;
    endtask

    task automatic test_div_min();
        for (int dv = 0; dv < 2; dv++) begin
            do_reset();
            div    = 8'(dv);
            mode   = 2'd0;
            enable = 1'b1;
            for (int i = 0; i < 4; i++) begin
                #1;
                checks++;
                if (adc_clk !== ((i % 2) == 0)) begin
                    errors++;
                    $display("FAIL divmin%0d_adc_clk[%0d]: got %b expected %b", dv, i, adc_clk, ((i % 2) == 0));
                end
                checks++;
                if (u_if.out_valid !== (i >= 2)) begin
                    errors++;
                    $display("FAIL divmin%0d_valid[%0d]: got %b expected %b", dv, i, u_if.out_valid, (i >= 2));
                end
                @(negedge clk);
            end
            enable = 1'b0;
        end
    endtask

    task automatic test_patterns();
        logic [11:0] exp;
        int          k;
        // Alternating modes 1 and 3, consumer always ready.
        for (int m = 1; m <= 3; m += 2) begin
            do_reset();
            mode           = 2'(m);
            div            = 8'd2;
            u_if.out_ready = 1'b1;
            enable         = 1'b1;
            for (int p = 0; p <= 8; p++) begin
                #1;
                if (p >= 2 && (p % 2) == 0) begin
                    k = p / 2 - 1;
                    if (m == 1) exp = ((k % 2) == 1) ? 12'hFFF : 12'h000;
                    else        exp = ((k % 2) == 1) ? 12'h555 : 12'hAAA;
                    exp = exp ^ MSBX;
                    checks++;
                    if (u_if.out_valid !== 1'b1 || u_if.out_data !== exp) begin
                        errors++;
                        $display("FAIL mode%0d_sample%0d: got v=%b d=%h expected v=1 d=%h", m, k, u_if.out_valid, u_if.out_data, exp);
                    end
                end
                @(negedge clk);
            end
        end
        // Ramp, run past the 12-bit wrap.
        do_reset();
        mode           = 2'd2;
        div            = 8'd2;
        u_if.out_ready = 1'b1;
        enable         = 1'b1;
        for (int p = 0; p <= 8196; p++) begin
            #1;
            if (p >= 2 && (p % 2) == 0) begin
                k = p / 2 - 1;
                if (k < 3 || k >= 4094) begin
                    exp = 12'(k) ^ MSBX;
                    checks++;
                    if (u_if.out_valid !== 1'b1 || u_if.out_data !== exp) begin
                        errors++;
                        $display("FAIL ramp_sample%0d: got v=%b d=%h expected v=1 d=%h", k, u_if.out_valid, u_if.out_data, exp);
                    end
                end
            end
            @(negedge clk);
        end
        enable         = 1'b0;
        u_if.out_ready = 1'b0;
    endtask

    task automatic test_div_change();
        logic [10:0] pat;
        pat = 11'b10001110011;
        do_reset();
        div    = 8'd4;
        mode   = 2'd0;
        enable = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            if (i == 1) div = 8'd6;
            #1;
            checks++;
            if (adc_clk !== pat[i]) begin
                errors++;
                $display("FAIL divchg_adc_clk[%0d]: got %b expected %b", i, adc_clk, pat[i]);
            end
            if (i == 3 || i == 4) begin
                checks++;
                if (u_if.out_valid !== (i == 4)) begin
                    errors++;
                    $display("FAIL divchg_valid[%0d]: got %b expected %b", i, u_if.out_valid, (i == 4));
                end
            end
            @(negedge clk);
        end
        enable = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        mode   = 2'd2;
        div    = 8'd2;
        enable = 1'b1;
        repeat (14) @(negedge clk);
        enable = 1'b0;
        #1;
        checks++;
        if (u_if.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_valid: got %b expected 1", u_if.out_valid);
        end
        checks++;
        if (overflow_cnt !== 16'd3) begin
            errors++;
            $display("FAIL ovf_count: got %0d expected 3", overflow_cnt);
        end
        u_if.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (u_if.out_data !== (12'(k) ^ MSBX)) begin
                errors++;
                $display("FAIL ovf_held%0d: got %h expected %h", k, u_if.out_data, 12'(k) ^ MSBX);
            end
            @(negedge clk);
        end
        u_if.out_ready = 1'b0;
        #1;
        checks++;
        if (u_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drained: got %b expected 0", u_if.out_valid);
        end
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        #1;
        checks++;
        if (overflow_cnt !== 16'd0) begin
            errors++;
            $display("FAIL ovf_clear: got %0d expected 0", overflow_cnt);
        end
    endtask

    task automatic test_clear_wins();
        do_reset();
        mode   = 2'd2;
        div    = 8'd2;
        enable = 1'b1;
        repeat (9) @(negedge clk);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        #1;
        checks++;
        if (overflow_cnt !== 16'd0) begin
            errors++;
            $display("FAIL clrwin_count: got %0d expected 0", overflow_cnt);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (overflow_cnt !== 16'd1) begin
            errors++;
            $display("FAIL clrwin_next_drop: got %0d expected 1", overflow_cnt);
        end
        enable = 1'b0;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        mode   = 2'd2;
        div    = 8'd2;
        enable = 1'b1;
        repeat (9) @(negedge clk);
        u_if.out_ready = 1'b1;
        @(negedge clk);
        u_if.out_ready = 1'b0;
        enable         = 1'b0;
        #1;
        checks++;
        if (overflow_cnt !== 16'd0) begin
            errors++;
            $display("FAIL fullpp_ovf: got %0d expected 0", overflow_cnt);
        end
        u_if.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++;
            if (u_if.out_valid !== 1'b1 || u_if.out_data !== (12'(k) ^ MSBX)) begin
                errors++;
                $display("FAIL fullpp_head%0d: got v=%b d=%h expected v=1 d=%h", k, u_if.out_valid, u_if.out_data, 12'(k) ^ MSBX);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (u_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fullpp_empty: got %b expected 0", u_if.out_valid);
        end
        u_if.out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        mode   = 2'd2;
        div    = 8'd2;
        enable = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (u_if.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre_valid: got %b expected 1", u_if.out_valid);
        end
        #2;
        nreset = 1'b0;
        #1;
        checks++;
        if (u_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_valid: got %b expected 0", u_if.out_valid);
        end
        checks++;
        if (u_if.out_data !== 12'h000) begin
            errors++;
            $display("FAIL arst_data: got %h expected 000", u_if.out_data);
        end
        checks++;
        if (adc_clk !== 1'b0) begin
            errors++;
            $display("FAIL arst_adc_clk: got %b expected 0", adc_clk);
        end
        @(negedge clk);
        nreset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (u_if.out_valid !== 1'b1 || u_if.out_data !== (12'h000 ^ MSBX)) begin
            errors++;
            $display("FAIL arst_restart: got v=%b d=%h expected v=1 d=%h", u_if.out_valid, u_if.out_data, 12'h000 ^ MSBX);
        end
        enable = 1'b0;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        nreset         = 1'b0;
        enable         = 1'b0;
        div            = 8'd4;
        mode           = 2'd0;
        adc_data       = 12'h123;
        clr_overflow   = 1'b0;
        u_if.out_ready = 1'b0;

        test_reset();
        test_divider();
        test_div_min();
        test_patterns();
        test_div_change();
        test_overflow();
        test_clear_wins();
        test_full_push_pop();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
